// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register and next-PC selection for the
// single-cycle core. Picks sequential / branch / JAL / JALR targets, traps on
// misaligned control-flow targets, freezes on halt or trap, and counts
// retired instructions with saturation.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    // Reset value of the retired counter; nonzero only to exercise saturation
    parameter logic [31:0] COUNT_RESET  = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_branch_next,
    input  logic        i_is_branch,
    input  logic        i_is_jal,
    input  logic        i_is_jalr,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1_value,
    input  logic        i_stall,
    input  logic        i_halt_req,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_redirect,
    output logic        o_trap,
    output logic        o_halted,
    output logic [31:0] o_retired_count
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        r_redirect;
    logic        w_redirect_next;
    logic        r_trap;
    logic        w_trap_next;
    logic        r_halted;
    logic        w_halted_next;
    logic [31:0] r_retired_count;
    logic [31:0] w_retired_count_next;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_rel_target;
    logic [31:0] w_jalr_target;
    logic [31:0] w_target;
    logic        w_taken;
    logic        w_misaligned;
    logic [31:0] w_count_inc;

    // Candidate targets; all arithmetic wraps modulo 2^32
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_rel_target  = r_pc + i_imm;
    assign w_jalr_target = (i_rs1_value + i_imm) & 32'hFFFF_FFFE;

    // JALR outranks JAL, which outranks a conditional branch; branch_next only
    // matters when the instruction really is a branch
    assign w_taken      = i_is_jalr | i_is_jal | (i_is_branch & i_branch_next);
    assign w_target     = i_is_jalr ? w_jalr_target : w_rel_target;
    // JALR bit0 is already cleared, so checking both low bits is uniform
    assign w_misaligned = w_taken & (w_target[1:0] != 2'b00);

    // Counter sticks at all-ones instead of wrapping
    assign w_count_inc = (r_retired_count == 32'hFFFF_FFFF) ? r_retired_count
                                                             : r_retired_count + 32'd1;

    // State register: reset dominates everything, including stall and HALT
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state         <= ST_BOOT;
            r_pc            <= RESET_VECTOR;
            r_redirect      <= 1'b0;
            r_trap          <= 1'b0;
            r_halted        <= 1'b0;
            r_retired_count <= COUNT_RESET;
        end else begin
            r_state         <= w_state_next;
            r_pc            <= w_pc_next;
            r_redirect      <= w_redirect_next;
            r_trap          <= w_trap_next;
            r_halted        <= w_halted_next;
            r_retired_count <= w_retired_count_next;
        end
    end

    // Next-state / next-PC selection; default is to hold everything
    always_comb begin
        w_state_next         = r_state;
        w_pc_next            = r_pc;
        w_redirect_next      = r_redirect;
        w_trap_next          = r_trap;
        w_halted_next        = r_halted;
        w_retired_count_next = r_retired_count;
        case (r_state)
            ST_BOOT: begin
                // One warm-up cycle for instruction memory; nothing retires
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_halt_req) begin
                    // ECALL/EBREAK retires; target alignment is not examined
                    w_state_next         = ST_HALT;
                    w_halted_next        = 1'b1;
                    w_redirect_next      = 1'b0;
                    w_retired_count_next = w_count_inc;
                end else if (w_misaligned) begin
                    // Faulting instruction does not retire; pc stays on it
                    w_state_next  = ST_HALT;
                    w_trap_next   = 1'b1;
                    w_halted_next = 1'b1;
                end else if (!i_stall) begin
                    w_pc_next            = w_taken ? w_target : w_pc_plus4;
                    w_redirect_next      = w_taken;
                    w_retired_count_next = w_count_inc;
                end
            end
            ST_HALT: begin
                // Absorbing; only reset leaves
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    assign o_pc            = r_pc;
    assign o_pc_plus4      = w_pc_plus4;
    assign o_redirect      = r_redirect;
    assign o_trap          = r_trap;
    assign o_halted        = r_halted;
    assign o_retired_count = r_retired_count;

endmodule
